// File: rtl/instr_fetch_pkg.sv
// Shared types for the fetch stage: program counter, instruction word and
// the fetch FSM state encoding.
package definitions;

  typedef logic [7:0]  ProgramCounter;
  typedef logic [31:0] Instruction;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection for the fetch stage: start address, branch target
// (absolute or fd_pc-relative), sequential increment, or hold.
module pc_next
  import definitions::*;
(
  input  fetch_state_t  state,
  input  logic          start,
  input  ProgramCounter start_addr,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          branch_rel,
  input  ProgramCounter branch_target,
  input  logic [7:0]    branch_offset,
  input  logic          halt_req,
  input  ProgramCounter pc,
  input  ProgramCounter fd_pc,
  output ProgramCounter pc_nxt
);

  ProgramCounter rel_target;

  always_comb begin
    // Size cast of a signed operand sign-extends the offset to PC width.
    rel_target = fd_pc + ProgramCounter'($signed(branch_offset));
    pc_nxt     = pc;
    unique case (state)
      IDLE, HALTED: begin
        if (start) pc_nxt = start_addr;
      end
      RUN: begin
        if (halt_req)       pc_nxt = pc;
        else if (branch_en) pc_nxt = branch_rel ? rel_target : branch_target;
        else if (stall)     pc_nxt = pc;
        else                pc_nxt = pc + ProgramCounter'(1);
      end
      default: pc_nxt = pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives the instruction ROM address and registers
// the returned word into the F/D pipeline register with a saturating count.
module instr_fetch
  import definitions::*;
#(
  parameter int IW = 4,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          start,
  input  ProgramCounter start_addr,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          branch_rel,
  input  ProgramCounter branch_target,
  input  logic [7:0]    branch_offset,
  input  logic          halt_req,
  output ProgramCounter rom_addr,
  input  Instruction    rom_instr,
  output Instruction    fd_instr,
  output ProgramCounter fd_pc,
  output logic          fd_valid,
  output logic          running,
  output logic          done,
  output logic [CW-1:0] fetch_count
);

  // The ROM decodes only pc[IW-1:0]; its index cannot exceed the PC width.
  if (IW < 1 || IW > $bits(ProgramCounter)) begin : g_iw_check
    $error("instr_fetch: IW must be between 1 and the PC width");
  end

  fetch_state_t  state;
  ProgramCounter pc;
  ProgramCounter pc_nxt;

  assign rom_addr = pc;

  pc_next u_pc_next (
    .state         (state),
    .start         (start),
    .start_addr    (start_addr),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_rel    (branch_rel),
    .branch_target (branch_target),
    .branch_offset (branch_offset),
    .halt_req      (halt_req),
    .pc            (pc),
    .fd_pc         (fd_pc),
    .pc_nxt        (pc_nxt)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      pc          <= '0;
      fd_instr    <= '0;
      fd_pc       <= '0;
      fd_valid    <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc <= pc_nxt;
      unique case (state)
        IDLE, HALTED: begin
          if (start) begin
            state       <= RUN;
            running     <= 1'b1;
            done        <= 1'b0;
            fetch_count <= '0;
          end
        end
        RUN: begin
          if (halt_req) begin
            state    <= HALTED;
            running  <= 1'b0;
            done     <= 1'b1;
            fd_valid <= 1'b0;
          end else if (branch_en) begin
            fd_valid <= 1'b0;
          end else if (!stall) begin
            fd_instr <= rom_instr;
            fd_pc    <= pc;
            fd_valid <= 1'b1;
            if (fetch_count != '1) fetch_count <= fetch_count + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, async reset
// sequence, and randomized traffic against a behavioural model.
module tb_instr_fetch;
  import definitions::*;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          start;
  ProgramCounter start_addr;
  logic          stall;
  logic          branch_en;
  logic          branch_rel;
  ProgramCounter branch_target;
  logic [7:0]    branch_offset;
  logic          halt_req;

  ProgramCounter rom_addr, rom_addr_s;
  Instruction    rom_instr, rom_instr_s;
  Instruction    fd_instr, fd_instr_s;
  ProgramCounter fd_pc, fd_pc_s;
  logic          fd_valid, fd_valid_s;
  logic          running, running_s;
  logic          done, done_s;
  logic [15:0]   fetch_count;
  logic [1:0]    fetch_count_s;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom_word(input logic [3:0] a);
    return 32'h11111111 * {28'd0, a};
  endfunction

  assign rom_instr   = rom_word(rom_addr[3:0]);
  assign rom_instr_s = rom_word(rom_addr_s[3:0]);

  instr_fetch #(.IW(4), .CW(16)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .start_addr(start_addr),
    .stall(stall), .branch_en(branch_en), .branch_rel(branch_rel),
    .branch_target(branch_target), .branch_offset(branch_offset),
    .halt_req(halt_req), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .fd_instr(fd_instr), .fd_pc(fd_pc), .fd_valid(fd_valid),
    .running(running), .done(done), .fetch_count(fetch_count)
  );

  instr_fetch #(.IW(4), .CW(2)) dut_small (
    .CLK(CLK), .Reset(Reset), .start(start), .start_addr(start_addr),
    .stall(stall), .branch_en(branch_en), .branch_rel(branch_rel),
    .branch_target(branch_target), .branch_offset(branch_offset),
    .halt_req(halt_req), .rom_addr(rom_addr_s), .rom_instr(rom_instr_s),
    .fd_instr(fd_instr_s), .fd_pc(fd_pc_s), .fd_valid(fd_valid_s),
    .running(running_s), .done(done_s), .fetch_count(fetch_count_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers, rules applied in priority order.
  bit m_run, m_done, m_v;
  int m_pc, m_fdpc, m_cnt;
  logic [31:0] m_fdi;

  task automatic model_reset();
    m_run = 0; m_done = 0; m_v = 0;
    m_pc = 0; m_fdpc = 0; m_cnt = 0; m_fdi = '0;
  endtask

  task automatic model_step();
    if (!m_run) begin
      if (start) begin
        m_pc = int'(start_addr); m_cnt = 0; m_run = 1; m_done = 0;
      end
    end else if (halt_req) begin
      m_run = 0; m_done = 1; m_v = 0;
    end else if (branch_en) begin
      m_pc = branch_rel ? ((m_fdpc + int'($signed(branch_offset))) & 255)
                        : int'(branch_target);
      m_v = 0;
    end else if (!stall) begin
      m_fdi  = rom_word(4'(m_pc % 16));
      m_fdpc = m_pc;
      m_v    = 1;
      m_pc   = (m_pc + 1) & 255;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] sa, input logic sl,
                       input logic br, input logic rel, input logic [7:0] tg,
                       input logic [7:0] of, input logic hl);
    start = st; start_addr = sa; stall = sl; branch_en = br;
    branch_rel = rel; branch_target = tg; branch_offset = of; halt_req = hl;
  endtask

  task automatic check_model(input string tag);
    check({tag, " rom_addr"}, 32'(rom_addr), 32'(m_pc));
    check({tag, " fd_valid"}, 32'(fd_valid), 32'(m_v));
    check({tag, " fd_pc"}, 32'(fd_pc), 32'(m_fdpc));
    check({tag, " fd_instr"}, fd_instr, m_fdi);
    check({tag, " running"}, 32'(running), 32'(m_run));
    check({tag, " done"}, 32'(done), 32'(m_done));
    check({tag, " fetch_count"}, 32'(fetch_count), 32'(m_cnt));
    check({tag, " count_cw2"}, 32'(fetch_count_s), 32'((m_cnt > 3) ? 3 : m_cnt));
  endtask

  typedef struct {
    logic start; logic [7:0] sa; logic stall; logic br; logic rel;
    logic [7:0] tgt; logic [7:0] off; logic halt;
    logic [7:0] e_fdpc; logic [31:0] e_fdi; logic e_v; logic [15:0] e_cnt;
    logic e_run; logic e_done; logic [7:0] e_rom;
  } vec_t;

  vec_t vecs[$];

  initial begin
    drive(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    Reset = 1'b1;
    model_reset();
    #2;
    check_model("reset");
    @(negedge CLK);
    Reset = 1'b0;

    //            st sa     sl br rl tgt    off    hl  fdpc   fdi           v  cnt run dn rom
    vecs.push_back('{0, 8'h00, 1, 1, 0, 8'h55, 8'h00, 0, 8'h00, 32'h00000000, 0, 0, 0, 0, 8'h00});
    vecs.push_back('{1, 8'h03, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 32'h00000000, 0, 0, 1, 0, 8'h03});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h03, 32'h33333333, 1, 1, 1, 0, 8'h04});
    vecs.push_back('{1, 8'h40, 0, 0, 0, 8'h00, 8'h00, 0, 8'h04, 32'h44444444, 1, 2, 1, 0, 8'h05});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h05, 32'h55555555, 1, 3, 1, 0, 8'h06});
    vecs.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 8'h05, 32'h55555555, 1, 3, 1, 0, 8'h06});
    vecs.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 8'h05, 32'h55555555, 1, 3, 1, 0, 8'h06});
    vecs.push_back('{0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 8'h05, 32'h55555555, 1, 3, 1, 0, 8'h06});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h06, 32'h66666666, 1, 4, 1, 0, 8'h07});
    vecs.push_back('{0, 8'h00, 1, 1, 1, 8'h00, 8'hFC, 0, 8'h06, 32'h66666666, 0, 4, 1, 0, 8'h02});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h02, 32'h22222222, 1, 5, 1, 0, 8'h03});
    vecs.push_back('{0, 8'h00, 0, 1, 0, 8'hFF, 8'h00, 0, 8'h02, 32'h22222222, 0, 5, 1, 0, 8'hFF});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 32'hFFFFFFFF, 1, 6, 1, 0, 8'h00});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 32'h00000000, 1, 7, 1, 0, 8'h01});
    vecs.push_back('{0, 8'h00, 0, 1, 0, 8'h30, 8'h00, 1, 8'h00, 32'h00000000, 0, 7, 0, 1, 8'h01});
    vecs.push_back('{0, 8'h00, 1, 1, 0, 8'h80, 8'h00, 1, 8'h00, 32'h00000000, 0, 7, 0, 1, 8'h01});
    vecs.push_back('{1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 32'h00000000, 0, 0, 1, 0, 8'h00});
    vecs.push_back('{0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 32'h00000000, 1, 1, 1, 0, 8'h01});

    foreach (vecs[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      @(negedge CLK);
      drive(vecs[i].start, vecs[i].sa, vecs[i].stall, vecs[i].br, vecs[i].rel,
            vecs[i].tgt, vecs[i].off, vecs[i].halt);
      @(posedge CLK);
      #1;
      check({t, " fd_pc"}, 32'(fd_pc), 32'(vecs[i].e_fdpc));
      check({t, " fd_instr"}, fd_instr, vecs[i].e_fdi);
      check({t, " fd_valid"}, 32'(fd_valid), 32'(vecs[i].e_v));
      check({t, " fetch_count"}, 32'(fetch_count), 32'(vecs[i].e_cnt));
      check({t, " count_cw2"}, 32'(fetch_count_s),
            32'((vecs[i].e_cnt > 16'd3) ? 16'd3 : vecs[i].e_cnt));
      check({t, " running"}, 32'(running), 32'(vecs[i].e_run));
      check({t, " done"}, 32'(done), 32'(vecs[i].e_done));
      check({t, " rom_addr"}, 32'(rom_addr), 32'(vecs[i].e_rom));
    end

    // Asynchronous reset between edges while fetching.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      drive(0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);
    end
    @(negedge CLK);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_model("async_reset");
    @(negedge CLK);
    Reset = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      drive($urandom_range(15) == 0, 8'($urandom), $urandom_range(3) == 0,
            $urandom_range(9) == 0, 1'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(39) == 0);
      model_step();
      @(posedge CLK);
      #1;
      check_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch stage directly upstream of the instruction ROM. Holds the program counter, drives the ROM address, and registers the returned instruction into the fetch/decode (F/D) pipeline register for the decoder. Supports start, stall, absolute and PC-relative redirect, halt with flush, and a saturating fetched-instruction counter.

## Interface
Parameters:
- IW, 4, ROM index width; only `pc[IW-1:0]` selects a ROM word, matching the ROM's depth of 2**IW.
- CW, 16, width of `fetch_count`.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins execution at `start_addr`.
- start_addr  in  ProgramCounter  first PC after `start`.
- stall  in  1  decoder cannot accept; hold PC and the F/D register.
- branch_en  in  1  redirect request from decode/execute.
- branch_rel  in  1  1 = target is `fd_pc` + `branch_offset`; 0 = target is `branch_target`.
- branch_target  in  ProgramCounter  absolute redirect target.
- branch_offset  in  8  signed two's-complement offset.
- halt_req  in  1  stop fetching (halt instruction decoded).
- rom_addr  out  ProgramCounter  address to the instruction ROM; equals `pc`.
- rom_instr  in  Instruction  combinational ROM read data.
- fd_instr  out  Instruction  registered instruction to the decoder.
- fd_pc  out  ProgramCounter  PC of `fd_instr`.
- fd_valid  out  1  `fd_instr` is live.
- running  out  1  state is RUN.
- done  out  1  state is HALTED.
- fetch_count  out  CW  count of instructions loaded into F/D since the last `start`.

## Operation
- States: IDLE, RUN, HALTED. After reset the state is IDLE.
- IDLE:
  - `start` → load `pc` = `start_addr`, clear `fetch_count`, go to RUN.
  - All other inputs are ignored.
- RUN: each cycle, exactly one action applies, in this priority order:
  1. `halt_req` → go to HALTED; `fd_valid` = 0; `pc` holds.
  2. `branch_en` → `pc` = target; `fd_valid` = 0 (flush). Applies even when `stall` = 1.
  3. `stall` → `pc`, `fd_*`, and `fetch_count` hold.
  4. Otherwise → `fd_instr` = `rom_instr`, `fd_pc` = `pc`, `fd_valid` = 1, `pc` = `pc` + 1, `fetch_count` += 1.
- Target computation: relative target is `fd_pc` + sign-extended `branch_offset`, modulo 2^width(ProgramCounter).
- `fetch_count` saturates at all-ones and does not wrap.
- HALTED:
  - `done` = 1; `fd_valid` stays 0.
  - `start` → reload `pc` = `start_addr`, clear `fetch_count`, go to RUN.
  - `branch_en`, `stall`, and `halt_req` are ignored.
- `start` is ignored while in RUN.
- PC wrap-around: all-ones + 1 → 0, with no flag. ROM indexing uses the low IW bits only, so fetch addresses alias modulo 2**IW.

## Timing
- Reset values: `pc` = 0, `rom_addr` = 0, `fd_instr` = 0, `fd_pc` = 0, `fd_valid` = 0, `running` = 0, `done` = 0, `fetch_count` = 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- `rom_addr` is combinational from the `pc` register; the ROM is combinational.
- Fetch latency: the instruction at `pc` appears on `fd_instr` one edge after `pc` is presented.
- First valid instruction: `start` sampled at edge N → `pc` = `start_addr` after N → `fd_valid` = 1 with `fd_pc` = `start_addr` after N+1.
- Redirect penalty: `branch_en` at edge N → bubble (`fd_valid` = 0) after N → target instruction valid after N+1, unless stalled.
- `stall` is sampled only at the clock edge. Holding `stall` keeps the F/D contents stable indefinitely.
- `running` and `done` are registered and change on the same edge as the state.

## Structure
- Package `definitions`: `ProgramCounter` (`logic [7:0]`), `Instruction` (`logic [31:0]`), and a fetch-state enum (IDLE, RUN, HALTED).
- Module `instr_fetch` contains the FSM, the PC register, the F/D register, and the counter.
- One natural sub-module: `pc_next`, combinational. It selects among `start_addr`, branch target, `pc` + 1, and `pc`, and contains the relative-offset adder.

## Test plan
- Start and sequential fetch: reset, then `start` with `start_addr` = 8'h03 and ROM[i] = i*0x11111111 → `fd_pc` sequence 3, 4, 5; `fd_instr` 0x33333333, 0x44444444, 0x55555555; `fetch_count` = 3.
- Stall: assert `stall` for 3 cycles while `fd_pc` = 5 → `fd_pc` = 5, `fd_valid` = 1, `rom_addr` = 6 for all 3 cycles; on release, `fd_pc` becomes 6.
- Relative branch with simultaneous stall: `fd_pc` = 8'h06, `branch_offset` = -4, `branch_rel` = 1, `stall` = 1 → next cycle `fd_valid` = 0 and `pc` = 2; following cycle `fd_pc` = 2.
- Absolute branch and wrap-around: `branch_target` = 8'hFF → `fd_pc` = FF, then 00; `rom_addr` low IW bits = F, then 0.
- Halt and restart: `halt_req` → `done` = 1, `running` = 0, `fd_valid` = 0; a `branch_en` while HALTED has no effect; `start` with `start_addr` = 0 → `fetch_count` clears and `fd_pc` = 0 two edges later.
- Asynchronous reset mid-run: assert `Reset` between edges → all outputs reach their reset values before the next edge; counter saturation checked separately with CW forced small (CW = 2: count stays at 3).
